// File: rtl/board_comm_pkg.sv
// Shared definitions for the board packet receiver.
//   - default timing/packet constants (65 MHz clock, 9600 baud, 16x oversampling)
//   - receiver state encoding
//   - 2-of-3 majority helper used for bit sampling
package board_comm_pkg;

   localparam int CLK_HZ        = 65_000_000;
   localparam int BAUD_RATE     = 9600;
   localparam int SAMP_PER_BIT  = 16;
   localparam int DIVISOR       = CLK_HZ / BAUD_RATE;          // clk cycles per bit
   localparam int CLK_PER_SAMP  = DIVISOR / SAMP_PER_BIT;      // 423
   localparam int PKT_LEN       = 208;                         // 26 bytes
   localparam int WAITING_COUNT = 130_000;                     // 2 ms inter-byte limit

   // IDLE/START/DATA/STOP live in the byte receiver; GAP is the packet-level
   // "bytes pending, line idle" condition held in the top.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_GAP
   } rx_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver with 16x oversampling.
// Ports:
//   clk_in, rst_in  : clock, synchronous active-high reset
//   rx              : asynchronous serial line (idle high, LSB first)
//   byte_out        : last received byte (stable while byte_valid is high)
//   byte_valid      : one-cycle pulse, byte_out holds a byte with a good stop bit
//   stop_err        : one-cycle pulse, stop bit sampled low
//   start_det       : combinational, falling edge accepted this cycle
//   busy            : receiver is in START/DATA/STOP
module uart_byte_rx #(
   parameter int CLK_PER_SAMP = board_comm_pkg::CLK_PER_SAMP,
   parameter int SAMP_PER_BIT = board_comm_pkg::SAMP_PER_BIT
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rx,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       stop_err,
   output logic       start_det,
   output logic       busy
);
   import board_comm_pkg::*;

   localparam int TICK_W = (CLK_PER_SAMP > 1) ? $clog2(CLK_PER_SAMP) : 1;
   localparam int SAMP_W = (SAMP_PER_BIT > 1) ? $clog2(SAMP_PER_BIT) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_PER_SAMP - 1);
   localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SAMP_PER_BIT - 1);
   // samp_q holds the number of ticks already elapsed in the bit, so the
   // tick numbered SAMP_PER_BIT/2 arrives while samp_q == SAMP_PER_BIT/2-1.
   localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(SAMP_PER_BIT / 2 - 1);
   localparam logic [SAMP_W-1:0] SAMP_PRE  = SAMP_W'(SAMP_PER_BIT / 2 - 2);
   localparam logic [SAMP_W-1:0] SAMP_POST = SAMP_W'(SAMP_PER_BIT / 2);

   logic [1:0]        sync_q, sync_d;
   logic              prev_q, prev_d;
   rx_state_e         state_q, state_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [SAMP_W-1:0] samp_q, samp_d;
   logic [3:0]        bit_q, bit_d;     // 0 = tail of start bit, 1..8 = data bits
   logic [1:0]        vote_q, vote_d;
   logic [7:0]        byte_q, byte_d;
   logic              byte_valid_q, byte_valid_d;
   logic              stop_err_q, stop_err_d;

   logic rx_s, fall, tick;

   assign rx_s = sync_q[1];
   assign fall = prev_q & ~rx_s;
   assign tick = (tick_q == TICK_LAST);

   always_comb begin
      sync_d       = {sync_q[0], rx};
      prev_d       = rx_s;
      state_d      = state_q;
      tick_d       = tick_q;
      samp_d       = samp_q;
      bit_d        = bit_q;
      vote_d       = vote_q;
      byte_d       = byte_q;
      byte_valid_d = 1'b0;
      stop_err_d   = 1'b0;
      start_det    = 1'b0;

      // Sample timebase runs continuously across START/DATA/STOP so bit
      // boundaries stay aligned to the start-bit falling edge.
      if (state_q != ST_IDLE) begin
         tick_d = tick ? '0 : tick_q + 1'b1;
         if (tick) samp_d = (samp_q == SAMP_LAST) ? '0 : samp_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (fall) begin
               state_d   = ST_START;
               tick_d    = '0;
               samp_d    = '0;
               bit_d     = '0;
               start_det = 1'b1;
            end
         end
         ST_START: begin
            if (tick && samp_q == SAMP_MID) state_d = rx_s ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            // DATA is entered at mid start bit; bit_q==0 covers the rest of it.
            if (tick && bit_q != 4'd0) begin
               if (samp_q == SAMP_PRE) vote_d[0] = rx_s;
               if (samp_q == SAMP_MID) vote_d[1] = rx_s;
               if (samp_q == SAMP_POST)
                  byte_d = {maj3(vote_q[0], vote_q[1], rx_s), byte_q[7:1]};
            end
            if (tick && samp_q == SAMP_LAST) begin
               if (bit_q == 4'd8) state_d = ST_STOP;
               else               bit_d   = bit_q + 4'd1;
            end
         end
         ST_STOP: begin
            if (tick && samp_q == SAMP_MID) begin
               state_d = ST_IDLE;
               if (rx_s) byte_valid_d = 1'b1;
               else      stop_err_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sync_q       <= 2'b11;
         prev_q       <= 1'b1;
         state_q      <= ST_IDLE;
         tick_q       <= '0;
         samp_q       <= '0;
         bit_q        <= '0;
         vote_q       <= '0;
         byte_q       <= '0;
         byte_valid_q <= 1'b0;
         stop_err_q   <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         prev_q       <= prev_d;
         state_q      <= state_d;
         tick_q       <= tick_d;
         samp_q       <= samp_d;
         bit_q        <= bit_d;
         vote_q       <= vote_d;
         byte_q       <= byte_d;
         byte_valid_q <= byte_valid_d;
         stop_err_q   <= stop_err_d;
      end
   end

   assign byte_out   = byte_q;
   assign byte_valid = byte_valid_q;
   assign stop_err   = stop_err_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: rtl/board_pkt_rx.sv
// Packet assembler on top of uart_byte_rx.
// Ports:
//   clk_in, rst_in : clock, synchronous active-high reset
//   rx             : asynchronous serial line
//   ready          : one-cycle pulse, data_out holds a new complete packet
//   data_out       : last complete packet, serial bit k -> data_out[k]
//   frame_err      : one-cycle pulse, packet aborted (bad stop bit or gap timeout)
module board_pkt_rx #(
   parameter int CLK_PER_SAMP  = board_comm_pkg::CLK_PER_SAMP,
   parameter int SAMP_PER_BIT  = board_comm_pkg::SAMP_PER_BIT,
   parameter int PKT_LEN       = board_comm_pkg::PKT_LEN,
   parameter int WAITING_COUNT = board_comm_pkg::WAITING_COUNT
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rx,
   output logic               ready,
   output logic [PKT_LEN-1:0] data_out,
   output logic               frame_err
);
   import board_comm_pkg::*;

   localparam int NBYTES = PKT_LEN / 8;
   localparam int N_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int GAP_W  = (WAITING_COUNT > 1) ? $clog2(WAITING_COUNT) : 1;

   logic [7:0] rx_byte;
   logic       byte_valid, stop_err, start_det, busy;

   logic [PKT_LEN-1:0] shadow_q, shadow_d;
   logic [PKT_LEN-1:0] data_q, data_d;
   logic [N_W-1:0]     n_q, n_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               ready_q, ready_d;
   logic               ferr_q, ferr_d;
   logic               in_gap;

   uart_byte_rx #(
      .CLK_PER_SAMP(CLK_PER_SAMP),
      .SAMP_PER_BIT(SAMP_PER_BIT)
   ) u_byte_rx (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rx        (rx),
      .byte_out  (rx_byte),
      .byte_valid(byte_valid),
      .stop_err  (stop_err),
      .start_det (start_det),
      .busy      (busy)
   );

   // GAP: at least one byte held and the byte receiver is idle. A START that
   // turns out to be a glitch drops back here with gap_q untouched.
   assign in_gap = (n_q != '0) && !busy;

   always_comb begin
      shadow_d = shadow_q;
      data_d   = data_q;
      n_d      = n_q;
      gap_d    = gap_q;
      ready_d  = 1'b0;
      ferr_d   = 1'b0;

      if (byte_valid) begin
         for (int i = 0; i < NBYTES; i++)
            if (n_q == N_W'(i)) shadow_d[8*i +: 8] = rx_byte;
         gap_d = '0;
         if (n_q == N_W'(NBYTES - 1)) begin
            data_d   = shadow_d;
            ready_d  = 1'b1;
            shadow_d = '0;
            n_d      = '0;
         end else begin
            n_d = n_q + 1'b1;
         end
      end else if (stop_err) begin
         ferr_d   = 1'b1;
         shadow_d = '0;
         n_d      = '0;
         gap_d    = '0;
      end else if (in_gap && !start_det) begin
         if (gap_q == GAP_W'(WAITING_COUNT - 1)) begin
            ferr_d   = 1'b1;
            shadow_d = '0;
            n_d      = '0;
            gap_d    = '0;
         end else begin
            gap_d = gap_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         shadow_q <= '0;
         data_q   <= '0;
         n_q      <= '0;
         gap_q    <= '0;
         ready_q  <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         data_q   <= data_d;
         n_q      <= n_d;
         gap_q    <= gap_d;
         ready_q  <= ready_d;
         ferr_q   <= ferr_d;
      end
   end

   assign ready     = ready_q;
   assign frame_err = ferr_q;
   assign data_out  = data_q;

endmodule

// File: tb/tb_board_pkt_rx.sv
// Directed bench for board_pkt_rx: a packet-level model turns every sent byte
// into expected ready/frame_err events; one compare process checks outputs
// every cycle against it, and each scenario pins literal results.
module tb_board_pkt_rx;
   import board_comm_pkg::*;

   localparam int CPS   = 4;
   localparam int SPB   = 16;
   localparam int PL    = 16;
   localparam int WC    = 200;
   localparam int BIT   = CPS * SPB;          // 64 cycles
   localparam int FRAME = 10 * BIT;
   // Stop-bit centre is 9.5 bit periods after the start edge; the sync,
   // edge detect and output registers add 4 cycles.
   localparam int LAT   = 9 * BIT + BIT / 2 + 4;
   localparam int EDGE  = 2;                  // line edge to detected fall
   localparam int TOL   = 2;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b1;
   logic          rx     = 1'b1;
   logic          ready, frame_err;
   logic [PL-1:0] data_out;

   board_pkt_rx #(
      .CLK_PER_SAMP (CPS),
      .SAMP_PER_BIT (SPB),
      .PKT_LEN      (PL),
      .WAITING_COUNT(WC)
   ) dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rx       (rx),
      .ready    (ready),
      .data_out (data_out),
      .frame_err(frame_err)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct {
      bit            is_rdy;
      int            t;
      logic [PL-1:0] data;
   } ev_t;

   ev_t           evq[$];
   logic [7:0]    part[$];
   bit            pend = 0;
   int            gap_start = 0;
   logic [PL-1:0] exp_data = '0;

   int total = 0, bad = 0;
   int n_rdy = 0, n_ferr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void push_ev(input bit r, input int t, input logic [PL-1:0] d);
      ev_t e;
      e.is_rdy = r;
      e.t      = t;
      e.data   = d;
      evq.push_back(e);
   endfunction

   // Packet model: a byte with a good stop bit joins the pending packet, a full
   // packet is published, a bad stop bit or an over-long gap drops it.
   task automatic model_byte(input int s, input logic [7:0] v, input bit stop_ok);
      logic [PL-1:0] d;
      if (pend && s + EDGE >= gap_start + WC) begin
         push_ev(1'b0, gap_start + WC, '0);
         part.delete();
      end
      pend = 0;
      if (!stop_ok) begin
         push_ev(1'b0, s + LAT, '0);
         part.delete();
      end else begin
         part.push_back(v);
         if (part.size() == PL / 8) begin
            d = '0;
            for (int i = 0; i < PL / 8; i++) d[8*i +: 8] = part[i];
            push_ev(1'b1, s + LAT, d);
            part.delete();
         end else begin
            pend      = 1;
            gap_start = s + LAT;
         end
      end
   endtask

   task automatic idle(input int n);
      if (pend && gap_start + WC <= cyc + n) begin
         push_ev(1'b0, gap_start + WC, '0);
         part.delete();
         pend = 0;
      end
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   // spike >= 0 inverts the line for 3 cycles starting at that frame offset
   task automatic send_byte(input logic [7:0] v, input bit stop_ok, input int spike);
      logic [9:0] fr;
      logic       b;
      fr = {stop_ok, v, 1'b0};
      for (int k = 0; k < FRAME; k++) begin
         @(posedge clk_in);
         #1;
         if (k == 0) model_byte(cyc, v, stop_ok);
         b = fr[k / BIT];
         if (spike >= 0 && k >= spike && k < spike + 3) b = ~b;
         rx = b;
      end
      if (!stop_ok) begin
         @(posedge clk_in);
         #1 rx = 1'b1;
      end
   endtask

   task automatic do_reset(input int n);
      rst_in   = 1'b1;
      part.delete();
      pend     = 0;
      exp_data = '0;
      repeat (n) @(posedge clk_in);
      #1 rst_in = 1'b0;
   endtask

   always @(negedge clk_in) begin
      ev_t e;
      int  diff;
      if (!rst_in) begin
         chk("ready_and_ferr", 32'(ready & frame_err), 32'd0);
         if (ready || frame_err) begin
            if (ready)     n_rdy++;
            if (frame_err) n_ferr++;
            if (evq.size() == 0) begin
               chk("unexpected_pulse", {30'd0, ready, frame_err}, 32'd0);
            end else begin
               e = evq.pop_front();
               chk("pulse_kind", 32'(ready), 32'(e.is_rdy));
               diff = cyc - e.t;
               total++;
               if (diff < -TOL || diff > TOL) begin
                  bad++;
                  $display("FAIL pulse_time: pulse at cycle %0d, want %0d +/-%0d", cyc, e.t, TOL);
               end
               if (e.is_rdy) exp_data = e.data;
            end
         end else if (evq.size() > 0 && cyc > evq[0].t + TOL) begin
            total++;
            bad++;
            $display("FAIL pulse_missing: none by cycle %0d, want one at %0d (ready=%0d)",
                     cyc, evq[0].t, evq[0].is_rdy);
            void'(evq.pop_front());
         end
         chk("data_out", 32'(data_out), 32'(exp_data));
      end
   end

   initial begin
      int r0, f0;

      // reset state
      repeat (3) @(posedge clk_in);
      #1;
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_state", 32'(dut.u_byte_rx.state_q), 32'(ST_IDLE));
      rst_in = 1'b0;
      idle(20);

      // two bytes, starts 10 bit periods apart
      r0 = n_rdy; f0 = n_ferr;
      send_byte(8'hA5, 1'b1, -1);
      send_byte(8'h3C, 1'b1, -1);
      idle(50);
      chk("A_ready_cnt", 32'(n_rdy - r0), 32'd1);
      chk("A_ferr_cnt", 32'(n_ferr - f0), 32'd0);
      chk("A_data", 32'(data_out), 32'h3CA5);

      // 20-cycle low glitch on idle line
      r0 = n_rdy; f0 = n_ferr;
      @(posedge clk_in);
      #1 rx = 1'b0;
      repeat (20) @(posedge clk_in);
      #1 rx = 1'b1;
      idle(100);
      chk("B_ready_cnt", 32'(n_rdy - r0), 32'd0);
      chk("B_ferr_cnt", 32'(n_ferr - f0), 32'd0);
      chk("B_state", 32'(dut.u_byte_rx.state_q), 32'(ST_IDLE));

      // stop bit held low
      r0 = n_rdy; f0 = n_ferr;
      send_byte(8'h55, 1'b0, -1);
      idle(50);
      chk("C_ferr_cnt", 32'(n_ferr - f0), 32'd1);
      chk("C_ready_cnt", 32'(n_rdy - r0), 32'd0);
      chk("C_data", 32'(data_out), 32'h3CA5);

      // gap timeout, then a good packet
      r0 = n_rdy; f0 = n_ferr;
      send_byte(8'h77, 1'b1, -1);
      idle(300);
      chk("D_ferr_cnt", 32'(n_ferr - f0), 32'd1);
      chk("D_ready_cnt0", 32'(n_rdy - r0), 32'd0);
      send_byte(8'h02, 1'b1, -1);
      send_byte(8'h01, 1'b1, -1);
      idle(50);
      chk("D_ready_cnt1", 32'(n_rdy - r0), 32'd1);
      chk("D_data", 32'(data_out), 32'h0102);

      // 3-cycle spike on the centre sample of bit 3 (frame offsets 287..289)
      r0 = n_rdy; f0 = n_ferr;
      send_byte(8'h00, 1'b1, 4 * BIT + 7 * CPS + 3);
      send_byte(8'h81, 1'b1, -1);
      idle(50);
      chk("E_ready_cnt", 32'(n_rdy - r0), 32'd1);
      chk("E_data", 32'(data_out), 32'h8100);

      // reset mid-packet, then full packet
      r0 = n_rdy; f0 = n_ferr;
      send_byte(8'h11, 1'b1, -1);
      do_reset(3);
      chk("F_data_after_rst", 32'(data_out), 32'd0);
      idle(250);
      send_byte(8'hEF, 1'b1, -1);
      send_byte(8'hBE, 1'b1, -1);
      idle(50);
      chk("F_ferr_cnt", 32'(n_ferr - f0), 32'd0);
      chk("F_ready_cnt", 32'(n_rdy - r0), 32'd1);
      chk("F_data", 32'(data_out), 32'hBEEF);

      chk("events_left", 32'(evq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/board_pkt_rx.md
BOARD_PKT_RX -- requirements
Module: board_pkt_rx

Interface
REQ-001 Parameter CLK_PER_SAMP, default 423, meaning clk_in cycles per oversample tick (65 MHz / 9600 baud / 16).
REQ-002 Parameter SAMP_PER_BIT, default 16, meaning oversample ticks per serial bit.
REQ-003 Parameter PKT_LEN, default 208, meaning payload bits per packet; must be a multiple of 8 (26 bytes at default).
REQ-004 Parameter WAITING_COUNT, default 130_000, meaning the maximum idle clk_in cycles between bytes of one packet (2 ms).
REQ-005 Port clk_in  input  1  system clock (65 MHz); the only clock.
REQ-006 Port rst_in  input  1  synchronous, active-high reset.
REQ-007 Port rx  input  1  asynchronous serial line: idle high, 8N1, LSB first.
REQ-008 Port ready  output  1  one-cycle pulse when data_out holds a complete new packet.
REQ-009 Port data_out  output  PKT_LEN  last complete packet; serial bit k of the packet maps to data_out[k].
REQ-010 Port frame_err  output  1  one-cycle pulse when a packet is aborted.

Function
REQ-011 rx shall pass through a 2-flop synchronizer; all logic shall use the synchronized value.
REQ-012 A tick counter shall pulse once every CLK_PER_SAMP cycles while in any state other than IDLE, and shall restart at 0 on each start-bit detection.
REQ-013 FSM states: IDLE, START, DATA, STOP, GAP.
REQ-014 IDLE -> START on a synchronized high-to-low edge of rx; the byte counter shall clear to 0.
REQ-015 START: at tick SAMP_PER_BIT/2, if rx is low go to DATA, else return to IDLE with no error (glitch rejection).
REQ-016 DATA: each bit shall be sampled as the 2-of-3 majority of ticks SAMP_PER_BIT/2-1, /2 and /2+1 within the bit.
REQ-017 After 8 bits DATA shall go to STOP, with bits shifted LSB first.
REQ-018 STOP: at mid-bit, rx low shall raise frame_err, discard the partial packet and go to IDLE.
REQ-019 STOP: at mid-bit, rx high shall write the byte into the shadow register at bits [8*n+7 : 8*n] and increment n.
REQ-020 After a good stop bit, if n == PKT_LEN/8, the shadow register shall copy to data_out and ready shall pulse in the next cycle; the FSM shall then go to IDLE.
REQ-021 After a good stop bit with fewer than PKT_LEN/8 bytes, the FSM shall go to GAP.
REQ-022 GAP: a falling edge shall enter START with n retained.
REQ-023 GAP: WAITING_COUNT cycles without a falling edge shall pulse frame_err, discard the partial packet and go to IDLE.
REQ-024 START glitch rejection while n > 0 shall return to GAP rather than IDLE, with the gap counter not reset.
REQ-025 data_out shall change only on a ready pulse; a partial or aborted packet shall never be visible on data_out.
REQ-026 ready and frame_err shall never assert in the same cycle; each pulse lasts exactly one cycle.
REQ-027 A falling edge in the cycle after ready shall be accepted as the first byte of a new packet.
REQ-028 Counters shall be sized by $clog2 of their parameter; no counter shall wrap within its state.

Reset
REQ-029 While rst_in is high: state=IDLE, all counters=0, synchronizer flops=1, shadow register=0, data_out=0, ready=0, frame_err=0.
REQ-030 rst_in asserted mid-packet shall discard the packet with no frame_err pulse.
REQ-031 After rst_in deasserts, reception shall resume only on a fresh falling edge.

Structure
REQ-032 Package board_comm_pkg shall hold the FSM state enum and the default constants: CLK_HZ, BAUD_RATE, SAMP_PER_BIT, CLK_PER_SAMP, PKT_LEN, WAITING_COUNT, DIVISOR.
REQ-033 The sub-module uart_byte_rx shall own the synchronizer, tick, START/DATA/STOP logic and majority voting, and shall output byte, byte_valid and stop_err.
REQ-034 board_pkt_rx shall own GAP, the byte counter, the shadow register and the ready/frame_err outputs.

Verification
REQ-035 Bench shall run with CLK_PER_SAMP=4, PKT_LEN=16 and WAITING_COUNT=200; bit period is 64 cycles.
REQ-036 Scenario: bytes 0xA5 then 0x3C, with a 10-bit-period gap -> one ready pulse, data_out=16'h3CA5, frame_err never high.
REQ-037 Scenario: 20-cycle low glitch on idle rx -> no ready, no frame_err, FSM back in IDLE.
REQ-038 Scenario: byte 0x55 sent with the stop bit held low -> one frame_err pulse, data_out unchanged.
REQ-039 Scenario: one byte, then no activity for 201 cycles -> frame_err pulses once; a following good 2-byte packet 0x0102 -> ready with data_out=16'h0102.
REQ-040 Scenario: single 3-cycle inverted spike at the sample centre of bit 3 of 0x00 -> majority vote yields 0x00.
REQ-041 Scenario: rst_in pulsed after the first byte of a packet, then a full packet 0xBEEF -> no frame_err, data_out=16'hBEEF after reset reads 0.
